// File: rtl/pwm_multi_pkg.sv
// Shared constants and types for the multi-channel PWM generator:
// register map, CTRL bit positions and the CTRL readback helper.
package pwm_multi_pkg;

    localparam logic [7:0] ADDR_CTRL      = 8'h00;
    localparam logic [7:0] ADDR_PERIOD    = 8'h01;
    localparam logic [7:0] ADDR_COUNT     = 8'h02;
    localparam logic [7:0] ADDR_STATUS    = 8'h03;
    localparam logic [7:0] ADDR_DUTY_BASE = 8'h10;

    localparam int EN_BIT  = 0;
    localparam int INV_BIT = 1;
    localparam int UPD_BIT = 2;

    localparam int MAX_CH = 32;

    typedef struct packed {
        logic upd;
        logic inv;
        logic en;
    } ctrl_t;

    function automatic logic [31:0] ctrl_word(input ctrl_t c);
        logic [31:0] w;
        w          = '0;
        w[EN_BIT]  = c.en;
        w[INV_BIT] = c.inv;
        w[UPD_BIT] = c.upd;
        return w;
    endfunction

endpackage

// File: rtl/pwm_multi_if.sv
// Avalon-MM register port of the PWM generator, with host (master) and
// peripheral (slave) views.
interface pwm_multi_if;

    logic [7:0]  s0_address;
    logic        s0_read;
    logic [31:0] s0_readdata;
    logic        s0_write;
    logic [31:0] s0_writedata;

    modport master (
        output s0_address,
        output s0_read,
        output s0_write,
        output s0_writedata,
        input  s0_readdata
    );

    modport slave (
        input  s0_address,
        input  s0_read,
        input  s0_write,
        input  s0_writedata,
        output s0_readdata
    );

endinterface

// File: rtl/pwm_multi_ch.sv
// One PWM channel: double-buffered duty register and the registered
// strict-less-than comparator against the shared period counter.
module pwm_multi_ch #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] i_count,
    input  logic             i_commit,
    input  logic             i_wr,
    input  logic [CNT_W-1:0] i_wdata,
    input  logic             i_inv,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_duty_shd,
    output logic             o_pwm
);

    logic [CNT_W-1:0] r_duty_shd;
    logic [CNT_W-1:0] r_duty_act;
    logic             r_pwm;
    logic             w_active;

    // Disabled channels idle at the INV level regardless of duty.
    assign w_active = i_en && (i_count < r_duty_act);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_duty_shd <= '0;
            r_duty_act <= '0;
            r_pwm      <= 1'b0;
        end else begin
            if (i_wr) begin
                r_duty_shd <= i_wdata;
            end
            if (i_commit) begin
                r_duty_act <= r_duty_shd;
            end
            r_pwm <= i_inv ^ w_active;
        end
    end

    assign o_duty_shd = r_duty_shd;
    assign o_pwm      = r_pwm;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM top: register decode, shared period counter,
// CTRL/STATUS and registered readback; channels live in pwm_multi_ch.
module pwm_multi
    import pwm_multi_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    pwm_multi_if.slave        s0,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              period_tick
);

    ctrl_t            r_ctrl;
    logic             r_wrap;
    logic             r_tick;
    logic [CNT_W-1:0] r_period_shd;
    logic [CNT_W-1:0] r_period_act;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_readdata;

    logic [CNT_W-1:0] w_wdata;
    logic             w_wr_ctrl;
    logic             w_wr_period;
    logic             w_wr_status;
    logic             w_wrap;
    logic             w_commit;
    logic [31:0]      w_rd_mux;
    logic [CNT_W-1:0] w_duty_shd [NUM_CH];

    assign w_wdata     = s0.s0_writedata[CNT_W-1:0];
    assign w_wr_ctrl   = s0.s0_write && (s0.s0_address == ADDR_CTRL);
    assign w_wr_period = s0.s0_write && (s0.s0_address == ADDR_PERIOD);
    assign w_wr_status = s0.s0_write && (s0.s0_address == ADDR_STATUS);

    // A commit lands on a wrap, or immediately while disabled since there is
    // no running period to protect.
    assign w_wrap   = r_ctrl.en && (r_count == r_period_act);
    assign w_commit = r_ctrl.upd && (w_wrap || !r_ctrl.en);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ctrl       <= '0;
            r_wrap       <= 1'b0;
            r_tick       <= 1'b0;
            r_period_shd <= '0;
            r_period_act <= '0;
            r_count      <= '0;
            r_readdata   <= '0;
        end else begin
            if (w_wr_ctrl) begin
                r_ctrl.en  <= s0.s0_writedata[EN_BIT];
                r_ctrl.inv <= s0.s0_writedata[INV_BIT];
            end
            // A fresh UPD request outranks the clear of the commit it races.
            r_ctrl.upd <= (w_wr_ctrl && s0.s0_writedata[UPD_BIT])
                          || (r_ctrl.upd && !w_commit);

            if (w_wr_period) begin
                r_period_shd <= w_wdata;
            end
            if (w_commit) begin
                r_period_act <= r_period_shd;
            end

            if (!r_ctrl.en || w_wrap) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + CNT_W'(1);
            end

            r_tick <= w_wrap;
            r_wrap <= w_wrap || (r_wrap && !(w_wr_status && s0.s0_writedata[0]));

            r_readdata <= s0.s0_read ? w_rd_mux : 32'd0;
        end
    end

    always_comb begin
        w_rd_mux = '0;
        case (s0.s0_address)
            ADDR_CTRL:   w_rd_mux = ctrl_word(r_ctrl);
            ADDR_PERIOD: w_rd_mux = 32'(r_period_shd);
            ADDR_COUNT:  w_rd_mux = 32'(r_count);
            ADDR_STATUS: w_rd_mux = 32'(r_wrap);
            default: begin
                for (int n = 0; n < NUM_CH; n++) begin
                    if (s0.s0_address == ADDR_DUTY_BASE + 8'(n)) begin
                        w_rd_mux = 32'(w_duty_shd[n]);
                    end
                end
            end
        endcase
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic w_wr_duty;

        assign w_wr_duty = s0.s0_write && (s0.s0_address == ADDR_DUTY_BASE + 8'(gi));

        pwm_multi_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk        (clk),
            .rst        (reset),
            .i_count    (r_count),
            .i_commit   (w_commit),
            .i_wr       (w_wr_duty),
            .i_wdata    (w_wdata),
            .i_inv      (r_ctrl.inv),
            .i_en       (r_ctrl.en),
            .o_duty_shd (w_duty_shd[gi]),
            .o_pwm      (pwm_out[gi])
        );
    end

    assign s0.s0_readdata = r_readdata;
    assign period_tick    = r_tick;

endmodule
